traffic_junction_ctrl: RTL

- Phase scheduler for a two-road junction. It owns the main-road and side-road lamp heads and sequences them through green, yellow and all-red phases.
- Side road and pedestrian crossing get right-of-way only on request. Main road defaults to green.
- Sits above the cyclic lamp datapath. Lamp outputs use the same 3-bit RGY vector, index 0 = R, 1 = G, 2 = Y.

---
 rtl/traffic_junction_ctrl.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/traffic_junction_ctrl.sv
// traffic_junction_ctrl: phase scheduler for a two-road junction.
// Main road rests on green; the side road and the pedestrian crossing are
// served on request through yellow and all-red clearance phases.
// Lamp vectors are [0:2] = {R, G, Y}.
// Optional night flashing mode: define TRAFFIC_JUNCTION_NIGHT_FLASH_EN.
module traffic_junction_ctrl #(
  parameter int CNT_W        = 8,
  parameter int GREEN_TICKS  = 8,
  parameter int YELLOW_TICKS = 3,
  parameter int ALLRED_TICKS = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_en,
  input  logic       side_req,
  input  logic       ped_req,
`ifdef TRAFFIC_JUNCTION_NIGHT_FLASH_EN
  input  logic       night_mode,
`endif
  output logic [0:2] main_rgy,
  output logic [0:2] side_rgy,
  output logic       walk,
  output logic       ped_ack,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    INIT_RED = 3'd0,
    MAIN_GRN = 3'd1,
    MAIN_YEL = 3'd2,
    RED_A    = 3'd3,
    SIDE_GRN = 3'd4,
    SIDE_YEL = 3'd5,
    RED_B    = 3'd6
`ifdef TRAFFIC_JUNCTION_NIGHT_FLASH_EN
    ,FLASH   = 3'd7
`endif
  } state_t;

  localparam logic [CNT_W-1:0] GRN_LOAD  = CNT_W'(GREEN_TICKS - 1);
  localparam logic [CNT_W-1:0] YEL_LOAD  = CNT_W'(YELLOW_TICKS - 1);
  localparam logic [CNT_W-1:0] RED_LOAD  = CNT_W'(ALLRED_TICKS - 1);
  localparam logic [CNT_W-1:0] TMR_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] TMR_ONE   = CNT_W'(1);
  localparam logic [0:2]       LAMP_R    = 3'b100;
  localparam logic [0:2]       LAMP_G    = 3'b010;
  localparam logic [0:2]       LAMP_Y    = 3'b001;

  // Timer reload value for the phase being entered (length - 1).
  function automatic logic [CNT_W-1:0] phase_load(input state_t s);
    case (s)
      MAIN_GRN, SIDE_GRN:     phase_load = GRN_LOAD;
      MAIN_YEL, SIDE_YEL:     phase_load = YEL_LOAD;
      INIT_RED, RED_A, RED_B: phase_load = RED_LOAD;
      default:                phase_load = TMR_ZERO;
    endcase
  endfunction

  // Main-road lamp decode for steady (non-flashing) states.
  function automatic logic [0:2] main_lamp(input state_t s);
    case (s)
      MAIN_GRN: main_lamp = LAMP_G;
      MAIN_YEL: main_lamp = LAMP_Y;
      default:  main_lamp = LAMP_R;
    endcase
  endfunction

  // Side-road lamp decode for steady (non-flashing) states.
  function automatic logic [0:2] side_lamp(input state_t s);
    case (s)
      SIDE_GRN: side_lamp = LAMP_G;
      SIDE_YEL: side_lamp = LAMP_Y;
      default:  side_lamp = LAMP_R;
    endcase
  endfunction

  state_t           state_r, nxt_state_s;
  logic [CNT_W-1:0] timer_r, nxt_timer_s;
  logic             side_pend_r, ped_pend_r, walk_grant_r;
  logic             req_any_s, expire_s, enter_side_s, grant_nxt_s;
  logic [0:2]       main_nxt_s, side_nxt_s;
`ifdef TRAFFIC_JUNCTION_NIGHT_FLASH_EN
  logic             flash_on_r, flash_nxt_s;
`endif

  // Next-state, timer, walk grant and lamp decode for the coming edge.
  always_comb begin
    // Requests seen in the expiry cycle itself count for that expiry.
    req_any_s   = side_pend_r | ped_pend_r | side_req | ped_req;
    expire_s    = tick_en & (timer_r == TMR_ZERO);
    nxt_state_s = state_r;
    if (expire_s) begin
      case (state_r)
        INIT_RED: nxt_state_s = MAIN_GRN;
`ifdef TRAFFIC_JUNCTION_NIGHT_FLASH_EN
        MAIN_GRN: nxt_state_s = night_mode ? FLASH : (req_any_s ? MAIN_YEL : MAIN_GRN);
        RED_B:    nxt_state_s = night_mode ? FLASH : MAIN_GRN;
        FLASH:    nxt_state_s = night_mode ? FLASH : INIT_RED;
`else
        MAIN_GRN: nxt_state_s = req_any_s ? MAIN_YEL : MAIN_GRN;
        RED_B:    nxt_state_s = MAIN_GRN;
`endif
        MAIN_YEL: nxt_state_s = RED_A;
        RED_A:    nxt_state_s = SIDE_GRN;
        SIDE_GRN: nxt_state_s = SIDE_YEL;
        SIDE_YEL: nxt_state_s = RED_B;
        default:  nxt_state_s = INIT_RED;
      endcase
    end else begin
      nxt_state_s = state_r;
    end

    // Expired phases that hold (resting main green, flashing) keep timer at 0.
    if (expire_s) begin
      nxt_timer_s = (nxt_state_s != state_r) ? phase_load(nxt_state_s) : timer_r;
    end else if (tick_en) begin
      nxt_timer_s = timer_r - TMR_ONE;
    end else begin
      nxt_timer_s = timer_r;
    end

    // Walk is decided once on entry to side green and frozen for the phase.
    enter_side_s = (nxt_state_s == SIDE_GRN) && (state_r != SIDE_GRN);
    if (enter_side_s) begin
      grant_nxt_s = ped_pend_r | ped_req;
    end else if (nxt_state_s == SIDE_GRN) begin
      grant_nxt_s = walk_grant_r;
    end else begin
      grant_nxt_s = 1'b0;
    end

    main_nxt_s = main_lamp(nxt_state_s);
    side_nxt_s = side_lamp(nxt_state_s);
`ifdef TRAFFIC_JUNCTION_NIGHT_FLASH_EN
    // Flashing starts lit on entry and toggles on each tick.
    if (nxt_state_s != FLASH) begin
      flash_nxt_s = 1'b1;
    end else if (state_r != FLASH) begin
      flash_nxt_s = 1'b1;
    end else if (tick_en) begin
      flash_nxt_s = ~flash_on_r;
    end else begin
      flash_nxt_s = flash_on_r;
    end
    if (nxt_state_s == FLASH) begin
      main_nxt_s = flash_nxt_s ? LAMP_Y : 3'b000;
      side_nxt_s = flash_nxt_s ? LAMP_R : 3'b000;
    end else begin
      main_nxt_s = main_lamp(nxt_state_s);
      side_nxt_s = side_lamp(nxt_state_s);
    end
`endif
  end

  // Phase FSM, request latches and registered Moore outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= INIT_RED;
      timer_r      <= RED_LOAD;
      side_pend_r  <= 1'b0;
      ped_pend_r   <= 1'b0;
      walk_grant_r <= 1'b0;
      ped_ack      <= 1'b0;
      main_rgy     <= LAMP_R;
      side_rgy     <= LAMP_R;
`ifdef TRAFFIC_JUNCTION_NIGHT_FLASH_EN
      flash_on_r   <= 1'b1;
`endif
    end else begin
      state_r      <= nxt_state_s;
      timer_r      <= nxt_timer_s;
      side_pend_r  <= enter_side_s ? 1'b0 : (side_pend_r | side_req);
      ped_pend_r   <= enter_side_s ? 1'b0 : (ped_pend_r | ped_req);
      walk_grant_r <= grant_nxt_s;
      ped_ack      <= enter_side_s & grant_nxt_s;
      main_rgy     <= main_nxt_s;
      side_rgy     <= side_nxt_s;
`ifdef TRAFFIC_JUNCTION_NIGHT_FLASH_EN
      flash_on_r   <= flash_nxt_s;
`endif
    end
  end

  assign walk  = walk_grant_r;
  assign phase = state_r;

endmodule
